rv_write: RTL and testbench
===========================

RV_WRITE -- requirements
Module: rv_write

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous reset, active low.
REQ-002 Ports from the memory stage SHALL be:
- i_mem_valid  in  1  an instruction is presented.
- i_mem_rd  in  5  destination register.
- i_mem_reg_write  in  1  instruction writes rd.
- i_mem_is_load  in  1  result comes from the data bus.
- i_mem_funct3  in  3  load size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_mem_addr_lo  in  2  byte offset of the load address.
- i_mem_result  in  32  ALU or link result for non-loads.
REQ-003 Ports from the data bus SHALL be:
- i_data_ack  in  1  read data is valid.
- i_data_rdata  in  32  word-aligned read data.
REQ-004 Outputs SHALL be:
- o_write_rd  out  5  registered rd; feeds hazard forwarding.
- o_write_reg_write  out  1  registered write enable.
- o_write_data  out  32  registered write-back value.
- o_stall  out  1  combinational; holds the upstream pipe.
- o_retire  out  1  one-cycle pulse per completed instruction.

Function
REQ-005 FSM states SHALL be IDLE and WAIT_LOAD.
REQ-006 In IDLE, on i_mem_valid with a non-load, the block SHALL register rd, reg_write and i_mem_result.
- Those values appear on the outputs the next cycle (1-cycle latency), with o_retire=1.
REQ-007 In IDLE, on i_mem_valid with a load and i_data_ack=1 in the same cycle, the block SHALL register the aligned load data.
- Latency 1 cycle, as in REQ-006.
REQ-008 In IDLE, on i_mem_valid with a load and i_data_ack=0, the block SHALL capture rd, reg_write, funct3 and addr_lo.
- It enters WAIT_LOAD.
- o_stall=1 in that same cycle.
- o_write_reg_write=0 and o_retire=0 on the next edge.
REQ-009 In WAIT_LOAD, o_stall SHALL be 1 while i_data_ack=0.
- i_mem_valid and all other i_mem_* inputs are ignored.
REQ-010 In WAIT_LOAD, on i_data_ack=1, the block SHALL write back the aligned data from the captured fields.
- o_stall=0 in that cycle.
- Return to IDLE; outputs valid the next cycle with o_retire=1.
REQ-011 Load alignment SHALL work as follows.
- Byte: rdata[8*addr_lo+:8].
- Half: rdata[16*addr_lo[1]+:16]; addr_lo[0] is ignored.
- Word: the full rdata.
- Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Undefined funct3 values yield the full word.
REQ-012 o_write_reg_write SHALL be 0 whenever rd=0, even if reg_write=1.
- o_retire still pulses.
REQ-013 On any cycle without a completing instruction, o_write_reg_write and o_retire SHALL be 0.
- o_write_rd and o_write_data hold their last values.
REQ-014 i_data_ack in IDLE without a load presented SHALL be ignored.

Reset
REQ-015 Reset SHALL force the state to IDLE.
- Outputs: o_write_rd=0, o_write_reg_write=0, o_write_data=0, o_retire=0, o_stall=0.
- Captured load fields clear to 0.
REQ-016 Reset asserted in WAIT_LOAD SHALL abandon the pending load; an ack arriving after reset is ignored.

Configuration
REQ-017 With macro RV_WB_INSTRET_EN defined, the block SHALL add output o_instret (64 bits, reset 0).
- The counter increments by 1 on each cycle that o_retire is 1 and wraps from all-ones to 0.
- Without the macro, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-018 Shared definitions SHALL live in the common struct/define headers:
- the load funct3 constants;
- the FSM state enum;
- a write-back bus struct {rd, reg_write, data}.
REQ-019 Alignment and extension SHALL be a combinational sub-module, rv_load_align (inputs funct3, addr_lo, rdata; output data).

Verification
REQ-020 Benches SHALL cover these directed scenarios:
- ALU op rd=5, result 0x1234_5678 -> next cycle o_write_rd=5, o_write_data=0x1234_5678, o_write_reg_write=1, o_retire=1.
- LB, addr_lo=3, rdata=0x80FF_FFFF, ack the same cycle -> o_write_data=0xFFFF_FF80; LBU -> 0x0000_0080.
- LH, addr_lo=2, ack delayed 3 cycles -> o_stall high for exactly 3 cycles; new i_mem_valid ignored; data=sign-extended rdata[31:16].
- Non-load, rd=0, reg_write=1 -> o_write_reg_write=0, o_retire=1.
- Reset pulsed in WAIT_LOAD, then a late ack -> all outputs 0, no write-back.
- RV_WB_INSTRET_EN defined, 10 completions -> o_instret=10; counter preloaded to all-ones plus 1 completion -> 0.

Source files
------------

// File: rtl/rv_write_pkg.sv
// rv_write_pkg -- shared definitions for the write-back stage.
//   Load funct3 encodings, write-back FSM state enum, and the
//   registered write-back bus struct {rd, reg_write, data}.
package rv_write_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] data;
    } wb_bus_t;

endpackage

// File: rtl/rv_write_load_align.sv
// rv_load_align -- combinational load alignment and sign/zero extension.
//   i_funct3  : load size/sign (LB, LH, LW, LBU, LHU; others -> full word)
//   i_addr_lo : byte offset within the word
//   i_rdata   : word-aligned read data
//   o_data    : aligned, extended result
module rv_load_align
    import rv_write_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half-word select uses only addr_lo[1]; misaligned bit 0 is dropped.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/rv_write.sv
// rv_write -- pipeline write-back stage.
//   Registers ALU results or aligned load data for the register file.
//   A load whose data is not acknowledged in the issuing cycle parks the
//   stage in WAIT_LOAD and stalls the upstream pipe until i_data_ack.
// Ports:
//   i_clk, i_reset_n (async, active low)
//   i_mem_*          : instruction from the memory stage
//   i_data_ack/rdata : data-bus read response
//   o_write_*        : registered write-back bus (rd, we, data)
//   o_stall          : combinational upstream hold
//   o_retire         : one-cycle pulse per completed instruction
//   o_instret        : 64-bit retire counter, present only when
//                      RV_WB_INSTRET_EN is defined
module rv_write
    import rv_write_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_mem_valid,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_reg_write,
    input  logic        i_mem_is_load,
    input  logic [2:0]  i_mem_funct3,
    input  logic [1:0]  i_mem_addr_lo,
    input  logic [31:0] i_mem_result,
    input  logic        i_data_ack,
    input  logic [31:0] i_data_rdata,
    output logic [4:0]  o_write_rd,
    output logic        o_write_reg_write,
    output logic [31:0] o_write_data,
    output logic        o_stall,
    output logic        o_retire
`ifdef RV_WB_INSTRET_EN
    ,output logic [63:0] o_instret
`endif
);

    wb_state_t   r_state, w_state_nxt;
    wb_bus_t     r_wb, w_wb_nxt;
    logic        r_retire;
    logic [4:0]  r_ld_rd;
    logic        r_ld_reg_write;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_addr_lo;

    logic        w_stall, w_complete, w_capture;
    logic [2:0]  w_al_funct3;
    logic [1:0]  w_al_addr_lo;
    logic [31:0] w_load_data;

    // Aligner sees the captured fields while waiting, live fields otherwise.
    assign w_al_funct3  = (r_state == ST_WAIT_LOAD) ? r_ld_funct3  : i_mem_funct3;
    assign w_al_addr_lo = (r_state == ST_WAIT_LOAD) ? r_ld_addr_lo : i_mem_addr_lo;

    rv_load_align u_align (
        .i_funct3  (w_al_funct3),
        .i_addr_lo (w_al_addr_lo),
        .i_rdata   (i_data_rdata),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        w_capture   = 1'b0;
        w_wb_nxt    = '{rd: i_mem_rd, reg_write: i_mem_reg_write, data: i_mem_result};
        case (r_state)
            ST_IDLE: begin
                if (i_mem_valid) begin
                    if (!i_mem_is_load) begin
                        w_complete = 1'b1;
                    end else if (i_data_ack) begin
                        w_complete    = 1'b1;
                        w_wb_nxt.data = w_load_data;
                    end else begin
                        w_stall     = 1'b1;
                        w_capture   = 1'b1;
                        w_state_nxt = ST_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                w_wb_nxt = '{rd: r_ld_rd, reg_write: r_ld_reg_write, data: w_load_data};
                if (i_data_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_ld_rd        <= '0;
            r_ld_reg_write <= 1'b0;
            r_ld_funct3    <= '0;
            r_ld_addr_lo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_ld_rd        <= i_mem_rd;
                r_ld_reg_write <= i_mem_reg_write;
                r_ld_funct3    <= i_mem_funct3;
                r_ld_addr_lo   <= i_mem_addr_lo;
            end
        end
    end

    // rd/data hold between completions; only the enable and retire drop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wb     <= '0;
            r_retire <= 1'b0;
        end else if (w_complete) begin
            r_wb.rd        <= w_wb_nxt.rd;
            r_wb.reg_write <= w_wb_nxt.reg_write && (w_wb_nxt.rd != 5'd0);
            r_wb.data      <= w_wb_nxt.data;
            r_retire       <= 1'b1;
        end else begin
            r_wb.reg_write <= 1'b0;
            r_retire       <= 1'b0;
        end
    end

    assign o_write_rd        = r_wb.rd;
    assign o_write_reg_write = r_wb.reg_write;
    assign o_write_data      = r_wb.data;
    assign o_retire          = r_retire;
    // Held low during reset so a stalled load cannot leak through.
    assign o_stall           = w_stall & i_reset_n;

`ifdef RV_WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_instret <= '0;
        else            r_instret <= r_instret + {63'd0, r_retire};
    end

    assign o_instret = r_instret;
`endif

endmodule

// File: tb/tb_rv_write.sv
module tb_rv_write;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_mem_valid, i_mem_reg_write, i_mem_is_load, i_data_ack;
    logic [4:0]  i_mem_rd;
    logic [2:0]  i_mem_funct3;
    logic [1:0]  i_mem_addr_lo;
    logic [31:0] i_mem_result, i_data_rdata;
    logic [4:0]  o_write_rd;
    logic        o_write_reg_write, o_stall, o_retire;
    logic [31:0] o_write_data;
`ifdef RV_WB_INSTRET_EN
    logic [63:0] o_instret;
`endif

    rv_write dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_mem_valid(i_mem_valid), .i_mem_rd(i_mem_rd),
        .i_mem_reg_write(i_mem_reg_write), .i_mem_is_load(i_mem_is_load),
        .i_mem_funct3(i_mem_funct3), .i_mem_addr_lo(i_mem_addr_lo),
        .i_mem_result(i_mem_result), .i_data_ack(i_data_ack),
        .i_data_rdata(i_data_rdata), .o_write_rd(o_write_rd),
        .o_write_reg_write(o_write_reg_write), .o_write_data(o_write_data),
        .o_stall(o_stall), .o_retire(o_retire)
`ifdef RV_WB_INSTRET_EN
        , .o_instret(o_instret)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_mem_valid = 0; i_mem_rd = 0; i_mem_reg_write = 0; i_mem_is_load = 0;
        i_mem_funct3 = 0; i_mem_addr_lo = 0; i_mem_result = 0;
        i_data_ack = 0; i_data_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset_n = 0;
        step(); step();
        i_reset_n = 1;
    endtask

    // Reference alignment written from the load rules with shifts and masks.
    function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] val;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vt[12];

    // random-phase reference state
    logic        m_pend;
    logic [4:0]  m_rd;
    logic        m_rw;
    logic [2:0]  m_f3;
    logic [1:0]  m_alo;
    logic [4:0]  ex_rd;
    logic        ex_we, ex_ret, ex_stall;
    logic [31:0] ex_data;

    initial begin
        vt[0]  = '{0, 3'b000, 2'd0, 32'h1234_5678, 5'd5,  1, 32'h1234_5678, 1};
        vt[1]  = '{1, 3'b000, 2'd3, 32'h80FF_FFFF, 5'd6,  1, 32'hFFFF_FF80, 1};
        vt[2]  = '{1, 3'b100, 2'd3, 32'h80FF_FFFF, 5'd7,  1, 32'h0000_0080, 1};
        vt[3]  = '{1, 3'b001, 2'd2, 32'h80FF_FFFF, 5'd8,  1, 32'hFFFF_80FF, 1};
        vt[4]  = '{1, 3'b101, 2'd3, 32'h80FF_1234, 5'd9,  1, 32'h0000_80FF, 1};
        vt[5]  = '{1, 3'b010, 2'd1, 32'hDEAD_BEEF, 5'd10, 1, 32'hDEAD_BEEF, 1};
        vt[6]  = '{1, 3'b011, 2'd2, 32'hCAFE_F00D, 5'd11, 1, 32'hCAFE_F00D, 1};
        vt[7]  = '{1, 3'b000, 2'd0, 32'h0000_007F, 5'd12, 1, 32'h0000_007F, 1};
        vt[8]  = '{1, 3'b000, 2'd1, 32'h0000_8000, 5'd13, 1, 32'hFFFF_FF80, 1};
        vt[9]  = '{1, 3'b001, 2'd1, 32'h0000_8001, 5'd14, 1, 32'hFFFF_8001, 1};
        vt[10] = '{0, 3'b000, 2'd0, 32'h0BAD_F00D, 5'd0,  1, 32'h0BAD_F00D, 0};
        vt[11] = '{1, 3'b110, 2'd0, 32'h1357_9BDF, 5'd15, 0, 32'h1357_9BDF, 0};

        do_reset();
        check("reset_rd",   o_write_rd, 0);
        check("reset_we",   o_write_reg_write, 0);
        check("reset_data", o_write_data, 0);
        check("reset_ret",  o_retire, 0);
        check("reset_stall", o_stall, 0);

        // single-cycle table: loads acked in the issuing cycle
        for (int i = 0; i < 12; i++) begin
            i_mem_valid = 1; i_mem_is_load = vt[i].is_load; i_mem_funct3 = vt[i].f3;
            i_mem_addr_lo = vt[i].alo; i_mem_rd = vt[i].rd; i_mem_reg_write = vt[i].rw;
            i_mem_result = vt[i].is_load ? 32'h5555_AAAA : vt[i].val;
            i_data_rdata = vt[i].is_load ? vt[i].val : 32'hA5A5_A5A5;
            i_data_ack   = vt[i].is_load;
            #1 check($sformatf("vec%0d_stall", i), o_stall, 0);
            step();
            idle_inputs();
            check($sformatf("vec%0d_rd", i),   o_write_rd, vt[i].rd);
            check($sformatf("vec%0d_data", i), o_write_data, vt[i].exp_data);
            check($sformatf("vec%0d_we", i),   o_write_reg_write, vt[i].exp_we);
            check($sformatf("vec%0d_ret", i),  o_retire, 1);
            i_data_ack = 1; // stray ack in IDLE must be ignored
            step();
            i_data_ack = 0;
            check($sformatf("vec%0d_ret_drop", i), o_retire, 0);
            check($sformatf("vec%0d_we_drop", i),  o_write_reg_write, 0);
            check($sformatf("vec%0d_hold", i),     o_write_data, vt[i].exp_data);
        end

        // LH at addr_lo=2, ack three cycles late, intruding valid ignored
        begin
            int stalls = 0;
            i_mem_valid = 1; i_mem_is_load = 1; i_mem_funct3 = 3'b001; i_mem_addr_lo = 2;
            i_mem_rd = 5'd21; i_mem_reg_write = 1; i_data_ack = 0;
            for (int c = 0; c < 3; c++) begin
                #1 if (o_stall) stalls++;
                step();
                if (c == 0) check("lh_wait_ret", o_retire, 0);
                if (c == 0) check("lh_wait_we",  o_write_reg_write, 0);
                i_mem_valid = 1; i_mem_is_load = 0; i_mem_rd = 5'd9;
                i_mem_funct3 = 3'b000; i_mem_addr_lo = 0; i_mem_result = 32'h1111_1111;
            end
            i_data_ack = 1; i_data_rdata = 32'h9ABC_0000;
            #1 check("lh_ack_stall", o_stall, 0);
            check("lh_stall_cycles", stalls, 3);
            step();
            idle_inputs();
            check("lh_rd",   o_write_rd, 21);
            check("lh_data", o_write_data, 32'hFFFF_9ABC);
            check("lh_we",   o_write_reg_write, 1);
            check("lh_ret",  o_retire, 1);
            step();
        end

        // reset inside WAIT_LOAD abandons the load
        i_mem_valid = 1; i_mem_is_load = 1; i_mem_funct3 = 3'b010; i_mem_rd = 5'd3;
        i_mem_reg_write = 1;
        step();
        idle_inputs();
        #2 i_reset_n = 0;
        #1 check("rst_wait_stall", o_stall, 0);
        check("rst_wait_data", o_write_data, 0);
        check("rst_wait_rd",   o_write_rd, 0);
        #2 i_reset_n = 1;
        i_data_ack = 1; i_data_rdata = 32'hFFFF_FFFF;
        step();
        i_data_ack = 0;
        check("late_ack_we",   o_write_reg_write, 0);
        check("late_ack_ret",  o_retire, 0);
        check("late_ack_data", o_write_data, 0);
        check("late_ack_rd",   o_write_rd, 0);

        // randomized traffic against the reference model
        do_reset();
        m_pend = 0; m_rd = 0; m_rw = 0; m_f3 = 0; m_alo = 0;
        for (int c = 0; c < 400; c++) begin
            i_mem_valid     = ($urandom_range(0, 9) < 7);
            i_mem_is_load   = $urandom_range(0, 1);
            i_mem_rd        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            i_mem_reg_write = $urandom_range(0, 3) != 0;
            i_mem_funct3    = 3'($urandom);
            i_mem_addr_lo   = 2'($urandom);
            i_mem_result    = $urandom;
            i_data_ack      = $urandom_range(0, 1);
            i_data_rdata    = $urandom;
            ex_stall = 0;
            ex_ret   = 0;
            if (!m_pend) begin
                if (i_mem_valid && !i_mem_is_load) begin
                    ex_ret = 1; ex_rd = i_mem_rd; ex_we = i_mem_reg_write && i_mem_rd != 0;
                    ex_data = i_mem_result;
                end else if (i_mem_valid && i_data_ack) begin
                    ex_ret = 1; ex_rd = i_mem_rd; ex_we = i_mem_reg_write && i_mem_rd != 0;
                    ex_data = ref_align(i_mem_funct3, i_mem_addr_lo, i_data_rdata);
                end else if (i_mem_valid) begin
                    ex_stall = 1; m_pend = 1; m_rd = i_mem_rd; m_rw = i_mem_reg_write;
                    m_f3 = i_mem_funct3; m_alo = i_mem_addr_lo;
                end
            end else if (i_data_ack) begin
                ex_ret = 1; ex_rd = m_rd; ex_we = m_rw && m_rd != 0;
                ex_data = ref_align(m_f3, m_alo, i_data_rdata);
                m_pend = 0;
            end else begin
                ex_stall = 1;
            end
            if (!ex_ret) ex_we = 0;
            #1 check("rnd_stall", o_stall, ex_stall);
            step();
            check("rnd_ret", o_retire, ex_ret);
            check("rnd_we",  o_write_reg_write, ex_we);
            if (c > 0 || ex_ret) begin
                check("rnd_rd",   o_write_rd, (ex_ret || c > 0) ? ex_rd : 5'd0);
                check("rnd_data", o_write_data, ex_data);
            end
            if (c == 0 && !ex_ret) begin
                ex_rd = 0; ex_data = 0;
            end
        end

`ifdef RV_WB_INSTRET_EN
        do_reset();
        check("instret_reset", o_instret, 0);
        for (int k = 0; k < 10; k++) begin
            i_mem_valid = 1; i_mem_is_load = 0; i_mem_rd = 5'd1; i_mem_reg_write = 1;
            i_mem_result = k;
            step();
        end
        idle_inputs();
        step();
        check("instret_ten", o_instret, 10);
        force dut.r_instret = '1;
        #1 release dut.r_instret;
        check("instret_preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        i_mem_valid = 1; i_mem_rd = 5'd2; i_mem_reg_write = 1;
        step();
        idle_inputs();
        step();
        check("instret_wrap", o_instret, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
